dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the pipelined CPU's MEM stage and the slow, line-wide data memory. Serves load/store hits in the same cycle, sequences write-back and refill transfers on misses, and holds the pipeline with `cpu_stall_o` until the access completes. Also keeps saturating hit/miss counters for the bench's stall accounting.

## Interface
- `SETS`, 16: number of cache lines; power of two, 2..256; `IDX_W = log2(SETS)`
- `CNT_W`, 16: width of the performance counters
- `clk_i` in 1: clock, all state updates on rising edge
- `rst_i` in 1: synchronous, active-high reset
- `cpu_req_i` in 1: MEM-stage access valid; held with address/data stable while `cpu_stall_o`=1
- `cpu_we_i` in 1: 1 = store word, 0 = load word
- `cpu_addr_i` in 32: byte address; bits [1:0] ignored
- `cpu_wdata_i` in 32: store data
- `cpu_rdata_o` out 32: load data, valid when `cpu_req_i`=1 and `cpu_stall_o`=0
- `cpu_stall_o` out 1: pipeline stall request
- `mem_enable_o` out 1: memory transfer request
- `mem_write_o` out 1: 1 = write-back, 0 = refill
- `mem_addr_o` out 32: line address, bits [3:0] = 0
- `mem_wdata_o` out 128: line being written back
- `mem_rdata_i` in 128: refill line, valid with `mem_ack_i`
- `mem_ack_i` in 1: single-cycle transfer completion
- `hit_cnt_o` out CNT_W: hit count
- `miss_cnt_o` out CNT_W: miss count

## Operation
- Line = 4 words (128 b). Address split: word `[3:2]`, index `[IDX_W+3:4]`, tag `[31:IDX_W+4]`.
- Per line: valid bit, dirty bit, tag, 128-bit data; all internal registers.
- Word w of a line occupies bits `[32w+31:32w]` (little-endian word order, matching memory).
- hit = `cpu_req_i` & valid[idx] & (tag[idx] == addr tag).
- FSM states:
  - IDLE: on hit, load returns the word combinationally; store writes the word and sets dirty at the edge. On miss, go to WRITEBACK if the victim is valid and dirty, else to REFILL.
  - WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o` = {victim tag, idx, 4'b0}, `mem_wdata_o` = victim line. On `mem_ack_i`, clear dirty and go to REFILL.
  - REFILL: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o` = {req tag, idx, 4'b0}. On `mem_ack_i`, write `mem_rdata_i` into the line, set tag, valid=1, dirty=0, and go to IDLE.
- After REFILL the access replays in IDLE as a hit; a store miss merges its word at that point (write-allocate).
- `cpu_stall_o` = `cpu_req_i` & !(state==IDLE & hit). The logic is combinational, so the stall rises in the same cycle as the miss.
- `cpu_rdata_o` = 0 when the stall is high or there is no request.
- Memory outputs are a function of state (Moore). All `mem_*` outputs are 0 in IDLE.
- Counters:
  - `miss_cnt_o` +1 on each IDLE→WRITEBACK/REFILL transition.
  - `hit_cnt_o` +1 on each IDLE cycle with hit, including the replay after a refill.
  - Both saturate at all-ones.
- Once started, a transaction always completes. If `cpu_req_i` drops mid-miss, the refill still lands; there is no abort.
- `mem_ack_i` is ignored in IDLE.

## Timing
- Reset: state IDLE; all valid/dirty bits = 0; tags/data = 0; counters = 0; `mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_wdata_o` = 0. Applies mid-transfer too: the controller is in IDLE the cycle after reset. An ack arriving after reset is ignored.
- Hit latency 0: data is valid in the request cycle, no stall.
- Clean miss, memory ack latency L (ack L cycles after `mem_enable_o` rises):
  - stall high in cycle 0; REFILL in cycles 1..L;
  - IDLE hit in cycle L+1, stall low.
  - Total stalled cycles = L+1.
- Dirty miss: WRITEBACK takes L cycles, then REFILL takes L cycles. Stalled cycles = 2L+1.
- The memory samples address/data while `mem_enable_o`=1; they are stable from state entry until the ack edge.
- `mem_enable_o` drops for at least 0 cycles between WRITEBACK and REFILL. It may stay high, but `mem_write_o` and `mem_addr_o` change at that edge, and the memory must treat the change as a new request.

## Test plan
- Reset, then load 0x0000_0040 with memory line = {w3=4,w2=3,w1=2,w0=1} and L=10:
  - stall high for 11 cycles, then `cpu_rdata_o`=1;
  - `miss_cnt_o`=1, `hit_cnt_o`=1.
- Then load 0x44 and 0x4C: no stall, data 2 then 4, `hit_cnt_o`=3.
- Store 0xDEAD_BEEF to 0x48 (hit), then load 0x448 (same index 4, different tag):
  - WRITEBACK to `mem_addr_o`=0x40 with `mem_wdata_o`[95:64]=0xDEADBEEF;
  - then REFILL from 0x440;
  - total stall 21 cycles with L=10.
- Store miss to an invalid line at 0x80:
  - refill occurs, then the word is merged and the line is marked dirty;
  - a later conflicting miss at 0x480 writes back the merged word.
- Assert `rst_i` during REFILL, with ack arriving 3 cycles later:
  - state goes to IDLE, `mem_enable_o`=0, the ack is ignored;
  - the original address misses again.
- With CNT_W=4, perform 20 hits: `hit_cnt_o` holds at 15.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller between the
// MEM stage and a line-wide data memory, with saturating hit/miss counters.
//
// state     | meaning
// IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or REFILL
// WRITEBACK | write the dirty victim line to memory, wait for ack
// REFILL    | fetch the requested line from memory, wait for ack
module dcache_controller #(
  parameter int SETS  = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [127:0]      mem_wdata_o,
  input  logic [127:0]      mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t             state, state_nxt;
  logic [SETS-1:0]    valid, dirty;
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [127:0]       data_mem [SETS];

  logic [IDX_W-1:0]   idx, miss_idx;
  logic [TAG_W-1:0]   tag, miss_tag;
  logic [1:0]         word;
  logic               hit, idle_hit, miss_start;
  logic [CNT_W-1:0]   hit_cnt, miss_cnt;
  logic               unused_addr_lsb;

  assign idx             = cpu_addr_i[IDX_W+3:4];
  assign tag             = cpu_addr_i[31:IDX_W+4];
  assign word            = cpu_addr_i[3:2];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign hit        = cpu_req_i & valid[idx] & (tag_mem[idx] == tag);
  assign idle_hit   = (state == IDLE) & hit;
  assign miss_start = (state == IDLE) & cpu_req_i & ~hit;

  assign cpu_stall_o = cpu_req_i & ~idle_hit;
  assign cpu_rdata_o = idle_hit ? data_mem[idx][{word, 5'd0} +: 32] : 32'd0;
  assign hit_cnt_o   = hit_cnt;
  assign miss_cnt_o  = miss_cnt;

  // The miss index/tag are latched so a dropped or changed request cannot
  // redirect a transfer that is already under way.
  always_comb begin
    state_nxt    = state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_wdata_o  = 128'd0;
    case (state)
      IDLE: begin
        if (miss_start)
          state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_mem[miss_idx], miss_idx, 4'b0000};
        mem_wdata_o  = data_mem[miss_idx];
        if (mem_ack_i) state_nxt = REFILL;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag, miss_idx, 4'b0000};
        if (mem_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (miss_start) begin
        miss_idx <= idx;
        miss_tag <= tag;
        if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
      end

      if (idle_hit) begin
        if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
        if (cpu_we_i) begin
          data_mem[idx][{word, 5'd0} +: 32] <= cpu_wdata_i;
          dirty[idx] <= 1'b1;
        end
      end

      if (state == WRITEBACK && mem_ack_i)
        dirty[miss_idx] <= 1'b0;

      if (state == REFILL && mem_ack_i) begin
        data_mem[miss_idx] <= mem_rdata_i;
        tag_mem[miss_idx]  <= miss_tag;
        valid[miss_idx]    <= 1'b1;
        dirty[miss_idx]    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed accesses push expected load
// data and memory requests; separate monitors pop and compare.
module tb_dcache_controller;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o, mem_rdata_i;
  logic         mem_ack_i;
  logic [15:0]  hit_cnt_o, miss_cnt_o;

  logic [31:0]  c4_rdata;
  logic         c4_stall, c4_en, c4_wr;
  logic [31:0]  c4_addr;
  logic [127:0] c4_wdata;
  logic [3:0]   c4_hit, c4_miss;

  logic         mem_auto, ack_auto, ack_man;
  logic [127:0] rd_auto, rd_man;
  assign mem_ack_i   = mem_auto ? ack_auto : ack_man;
  assign mem_rdata_i = mem_auto ? rd_auto : rd_man;

  dcache_controller #(.SETS(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  // Same stimulus, 4-bit counters, to reach saturation quickly.
  dcache_controller #(.SETS(16), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(c4_rdata),
    .cpu_stall_o(c4_stall), .mem_enable_o(c4_en), .mem_write_o(c4_wr),
    .mem_addr_o(c4_addr), .mem_wdata_o(c4_wdata), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .hit_cnt_o(c4_hit), .miss_cnt_o(c4_miss)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } load_t;
  typedef struct { logic w; logic [31:0] a; logic [127:0] d; } mreq_t;

  load_t        cpu_q[$];
  mreq_t        mem_q[$];
  logic [127:0] mem_model [logic [31:0]];
  int           vectors = 0;
  int           miscompares = 0;
  int           lat = 10;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic push_mem(input logic w, input logic [31:0] a, input logic [127:0] d);
    mem_q.push_back('{w, a, d});
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_stall);
    int stalls = 0;
    bit done = 1'b0;
    if (!we) cpu_q.push_back('{a, exp_rd});
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = wd;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (cpu_stall_o) stalls++;
      else done = 1'b1;
    end
    check($sformatf("access_done@%h", a), done, 1);
    check($sformatf("stall_cycles@%h", a), stalls, exp_stall);
    @(posedge clk); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  // Load-data monitor: one completion per load at the stall-free negedge.
  initial begin
    load_t e;
    forever begin
      @(negedge clk);
      if (cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
        if (cpu_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL load_unexpected: got data %h at %h, expected no load", cpu_rdata_o, cpu_addr_i);
        end else begin
          e = cpu_q.pop_front();
          check($sformatf("load_data@%h", e.a), cpu_rdata_o, e.d);
        end
      end
    end
  end

  // Memory responder and request monitor; ack arrives in the lat-th enabled cycle.
  initial begin
    bit           active = 1'b0;
    int           cnt = 0;
    logic         cur_w = 1'b0;
    logic [31:0]  cur_a = '0;
    logic [127:0] cur_d = '0;
    mreq_t        e;
    ack_auto = 1'b0; rd_auto = '0;
    forever begin
      @(posedge clk); #1;
      ack_auto = 1'b0;
      if (!mem_auto || !mem_enable_o) begin
        active = 1'b0; cnt = 0;
      end else begin
        if (!active || mem_write_o != cur_w || mem_addr_o != cur_a) begin
          active = 1'b1; cnt = 0;
          cur_w = mem_write_o; cur_a = mem_addr_o; cur_d = mem_wdata_o;
          if (mem_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL mem_unexpected: got write=%0b addr %h, expected no request", cur_w, cur_a);
          end else begin
            e = mem_q.pop_front();
            check("mem_write", cur_w, e.w);
            check("mem_addr", cur_a, e.a);
            if (e.w) check($sformatf("mem_wdata@%h", e.a), cur_d, e.d);
          end
        end
        cnt++;
        if (cnt >= lat) begin
          ack_auto = 1'b1;
          if (cur_w) mem_model[cur_a] = cur_d;
          else rd_auto = mem_model.exists(cur_a) ? mem_model[cur_a] : 128'd0;
          active = 1'b0;
        end
      end
    end
  end

  initial begin
    mem_model[32'h40]  = {32'd4, 32'd3, 32'd2, 32'd1};
    mem_model[32'h440] = mk(32'h4400);
    mem_model[32'h80]  = mk(32'h80);
    mem_model[32'h480] = mk(32'h4800);
    mem_model[32'h100] = mk(32'h100);
    mem_auto = 1'b1; ack_man = 1'b0; rd_man = '0;
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_stall", cpu_stall_o, 0);
    check("rst_mem_enable", mem_enable_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_hit_cnt", hit_cnt_o, 0);
    check("rst_miss_cnt", miss_cnt_o, 0);

    // Clean miss, L=10.
    push_mem(1'b0, 32'h40, '0);
    access(1'b0, 32'h40, 0, 32'd1, 11);
    check("miss_cnt_a", miss_cnt_o, 1);
    check("hit_cnt_a", hit_cnt_o, 1);

    access(1'b0, 32'h44, 0, 32'd2, 0);
    access(1'b0, 32'h4C, 0, 32'd4, 0);
    check("hit_cnt_b", hit_cnt_o, 3);
    check("hit_cnt4_b", c4_hit, 3);

    // Store hit, then dirty conflict miss.
    access(1'b1, 32'h48, 32'hDEADBEEF, 0, 0);
    push_mem(1'b1, 32'h40, {32'd4, 32'hDEADBEEF, 32'd2, 32'd1});
    push_mem(1'b0, 32'h440, '0);
    access(1'b0, 32'h448, 0, 32'h4402, 21);
    check("miss_cnt_c", miss_cnt_o, 2);
    check("hit_cnt_c", hit_cnt_o, 5);

    // Clean victim; refill returns the written-back line.
    push_mem(1'b0, 32'h40, '0);
    access(1'b0, 32'h48, 0, 32'hDEADBEEF, 11);

    // Store miss to an invalid line, then conflict writes back the merged word.
    lat = 4;
    push_mem(1'b0, 32'h80, '0);
    access(1'b1, 32'h80, 32'hCAFEF00D, 0, 5);
    access(1'b0, 32'h80, 0, 32'hCAFEF00D, 0);
    access(1'b0, 32'h84, 0, 32'h81, 0);
    push_mem(1'b1, 32'h80, {32'h83, 32'h82, 32'h81, 32'hCAFEF00D});
    push_mem(1'b0, 32'h480, '0);
    access(1'b0, 32'h480, 0, 32'h4800, 9);
    check("miss_cnt_d", miss_cnt_o, 5);
    check("hit_cnt_d", hit_cnt_o, 10);
    check("hit_cnt4_d", c4_hit, 10);

    // Reset in the middle of a refill; a late ack must be ignored.
    mem_auto = 1'b0;
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    @(negedge clk);
    check("rstx_miss_stall", cpu_stall_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstx_refill_en", mem_enable_o, 1);
    check("rstx_refill_wr", mem_write_o, 0);
    check("rstx_refill_addr", mem_addr_o, 32'h100);
    @(posedge clk); #1;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rstx_idle_en", mem_enable_o, 0);
    check("rstx_idle_addr", mem_addr_o, 0);
    check("rstx_miss_cnt", miss_cnt_o, 0);
    @(posedge clk); #1;
    ack_man = 1'b1; rd_man = {4{32'hBAD0BAD0}};
    @(negedge clk);
    check("rstx_ack_en", mem_enable_o, 0);
    @(posedge clk); #1;
    ack_man = 1'b0;
    @(negedge clk);
    check("rstx_after_ack_en", mem_enable_o, 0);
    check("rstx_after_ack_hit", hit_cnt_o, 0);
    mem_auto = 1'b1;
    push_mem(1'b0, 32'h100, '0);
    access(1'b0, 32'h104, 0, 32'h101, 5);
    check("miss_cnt_e", miss_cnt_o, 1);
    check("hit_cnt_e", hit_cnt_o, 1);

    // Twenty hits: wide counter counts on, 4-bit counter saturates.
    for (int i = 0; i < 20; i++)
      access(1'b0, 32'h100 + 32'(4 * (i % 4)), 0, 32'h100 + 32'(i % 4), 0);
    check("hit_cnt_f", hit_cnt_o, 21);
    check("hit_cnt4_sat", c4_hit, 15);
    check("miss_cnt4_f", c4_miss, 1);

    repeat (3) @(posedge clk);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
